program_counter_stack: RTL and testbench
========================================

// Module: program_counter_stack
// PURPOSE
//  Parametrised program counter with a hardware return-address stack (CALL/RET) and wide jumps.
//  Sits in the fetch path in place of the fixed 8-bit PC and is driven by the mem micro-instruction.
//  The low PC bits come from the instruction immediate and the high bits from the data bus.
// PARAMETERS
//  PC_W        8   program counter width in bits
//  LO_W        4   low PC bits loaded from imm on SJMP/JMP/CALL; high part = PC_W-LO_W bits
//  WORD_W      4   bus_in width; must be >= PC_W-LO_W
//  STACK_DEPTH 4   return-address stack entries (>=1); SP_W = $clog2(STACK_DEPTH+1)
// PORTS
//  clk          in   1        clock; all state updates on the rising edge
//  reset        in   1        synchronous, active-low reset
//  ce           in   1        cycle enable
//  halt         in   1        freeze; holds all state while high
//  op           in   3        pc_op_e opcode
//  imm          in   LO_W     instruction immediate
//  bus_in       in   WORD_W   high-part jump target; bits [PC_W-LO_W-1:0] used
//  pc           out  PC_W     current program counter (registered)
//  sp           out  SP_W     stack occupancy, 0..STACK_DEPTH
//  stack_full   out  1        sp == STACK_DEPTH
//  stack_empty  out  1        sp == 0
//  stack_err    out  1        sticky overflow/underflow flag
// BEHAVIOUR
//  - Reset (reset==0 at the edge): pc=0, sp=0, stack_err=0; stack RAM contents don't-care. Reset wins over every op.
//  - Update qualifier: upd = ce & ~halt. When upd==0 all state holds and op is ignored.
//  - With upd==1, effective on the next edge; pc shows the new value the cycle after:
//    NOP  0: pc holds
//    INC  1: pc <= pc+1, modulo 2^PC_W (all-ones wraps to 0)
//    SJMP 2: pc[LO_W-1:0] <= imm; high bits unchanged (no increment)
//    JMP  3: pc <= {bus_in[PC_W-LO_W-1:0], imm}
//    CALL 4: push pc+1 (mod 2^PC_W); pc <= {bus_in[..], imm}; sp++
//    RET  5: pc <= top of stack; sp--
//    6: BRREL under the macro, else INC
//    7: reserved, behaves as INC
//  - CALL when stack_full: no push, sp unchanged, stack_err<=1, pc <= pc+1.
//  - RET when stack_empty: no pop, stack_err<=1, pc <= pc+1.
//  - stack_err stays set until reset. It has no other effect on operation.
//  - Stack is LIFO. Push writes entry[sp] and pop reads entry[sp-1], both in the same cycle.
//    No combinational path from op to pc.
//  - stack_full/stack_empty decoded combinationally from registered sp.
// CONFIGURATION
//  PC_BRANCH_REL_EN defined:
//    op 6 = BRREL: pc <= pc + sign_extend(imm) modulo 2^PC_W.
//    Example: imm=4'b1110 gives pc-2.
//  PC_BRANCH_REL_EN undefined: op 6 decodes as INC; no adder beyond the +1 incrementer.
// STRUCTURE
//  - pc_pkg: typedef enum logic [2:0] pc_op_e {PC_NOP, PC_INC, PC_SJMP, PC_JMP, PC_CALL, PC_RET, PC_BRREL, PC_RSVD}.
//    Also holds the default width constants.
//  - Sub-module pc_return_stack (DEPTH, WIDTH):
//    - inputs push, pop, din
//    - outputs dout, sp, full, empty
//    - guards against overflow/underflow internally
//  - Top: op decode, next-pc mux, stack_err register.
// TESTING (PC_W=8, LO_W=4, WORD_W=4, STACK_DEPTH=4)
//  1. reset=0 then INC x3 with ce=1 -> pc 0,1,2,3. Start at 8'hFF, INC -> 8'h00.
//  2. pc=8'h35, SJMP imm=4'hA -> 8'h3A. JMP imm=4'h2, bus_in=4'hC -> 8'hC2.
//     halt=1 during JMP -> pc holds.
//  3. pc=8'h10, CALL imm=4'h0, bus_in=4'h8 -> pc=8'h80, sp=1.
//     RET -> pc=8'h11, sp=0, stack_err=0.
//  4. Five nested CALLs -> 5th gives stack_full=1, stack_err=1, pc+1, sp=4.
//     Four RETs return addresses in reverse order.
//     Extra RET -> pc+1, sp=0, stack_err stays 1.
//  5. reset=0 asserted in the same cycle as CALL with sp=2 -> pc=0, sp=0, stack_err=0.
//  6. PC_BRANCH_REL_EN: pc=8'h05, BRREL imm=4'hE -> 8'h03; pc=8'hFF, imm=4'h3 -> 8'h02.
//     Without the macro: op 6 -> pc+1.

Source files
------------

// File: rtl/program_counter_stack_pkg.sv
// Shared types and default widths for the program counter / return-stack slice.
//  pc_op_e : 3-bit micro-op driving the program counter.
//  Default width constants are used as parameter defaults by the interface and the top.
package program_counter_stack_pkg;

  typedef enum logic [2:0] {
    PC_NOP   = 3'd0,
    PC_INC   = 3'd1,
    PC_SJMP  = 3'd2,
    PC_JMP   = 3'd3,
    PC_CALL  = 3'd4,
    PC_RET   = 3'd5,
    PC_BRREL = 3'd6,
    PC_RSVD  = 3'd7
  } pc_op_e;

  localparam int unsigned PcWDefault         = 8;
  localparam int unsigned LoWDefault         = 4;
  localparam int unsigned WordWDefault       = 4;
  localparam int unsigned StackDepthDefault  = 4;

endpackage

// File: rtl/program_counter_stack_if.sv
// Control/status bundle between the fetch sequencer and program_counter_stack.
//  master : drives ce, halt, op, imm, bus_in; observes pc, sp and stack flags.
//  slave  : the program counter itself.
// Widths must match the parameters of the program_counter_stack it connects to.
interface program_counter_stack_if #(
  parameter int unsigned PC_W        = program_counter_stack_pkg::PcWDefault,
  parameter int unsigned LO_W        = program_counter_stack_pkg::LoWDefault,
  parameter int unsigned WORD_W      = program_counter_stack_pkg::WordWDefault,
  parameter int unsigned STACK_DEPTH = program_counter_stack_pkg::StackDepthDefault
);
  import program_counter_stack_pkg::*;

  localparam int unsigned SP_W = $clog2(STACK_DEPTH + 1);

  logic              ce;
  logic              halt;
  pc_op_e            op;
  logic [LO_W-1:0]   imm;
  logic [WORD_W-1:0] bus_in;
  logic [PC_W-1:0]   pc;
  logic [SP_W-1:0]   sp;
  logic              stack_full;
  logic              stack_empty;
  logic              stack_err;

  modport master (
    output ce, halt, op, imm, bus_in,
    input  pc, sp, stack_full, stack_empty, stack_err
  );

  modport slave (
    input  ce, halt, op, imm, bus_in,
    output pc, sp, stack_full, stack_empty, stack_err
  );

endinterface

// File: rtl/program_counter_stack_return_stack.sv
// LIFO return-address stack with occupancy counter.
//  clk, reset     : clock, synchronous active-low reset (clears occupancy only)
//  push_i, din_i  : write din_i at entry[sp], sp++ (ignored when full)
//  pop_i          : sp-- (ignored when empty or when push_i is also high)
//  dout_o         : entry[sp-1], i.e. the current top of stack, combinational
//  sp_o           : occupancy 0..DEPTH
//  full_o/empty_o : decoded from the registered occupancy
module pc_return_stack #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned SP_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [SP_W-1:0]  sp_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SP_W-1:0] SpOne   = SP_W'(1);
  localparam logic [SP_W-1:0] SpDepth = SP_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [2**IDX_W];
  logic [SP_W-1:0]  sp_q, sp_d;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             do_push, do_pop;

  assign full_o  = (sp_q == SpDepth);
  assign empty_o = (sp_q == '0);

  // Guards live here so the top never has to qualify push/pop with the flags.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~push_i & ~empty_o;

  // sp < DEPTH whenever a write happens, so truncation to IDX_W is lossless.
  assign wr_idx = IDX_W'(sp_q);
  assign rd_idx = IDX_W'(sp_q - SpOne);
  assign dout_o = mem_q[rd_idx];
  assign sp_o   = sp_q;

  always_comb begin
    sp_d = sp_q;
    if (do_push) begin
      sp_d = sp_q + SpOne;
    end else if (do_pop) begin
      sp_d = sp_q - SpOne;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Storage needs no reset: entries above sp are never read.
  always_ff @(posedge clk) begin
    if (reset && do_push) begin
      mem_q[wr_idx] <= din_i;
    end
  end

endmodule

// File: rtl/program_counter_stack.sv
// Parametrised program counter with a hardware return-address stack and wide jumps.
// Low PC bits come from the instruction immediate, high bits from the data bus.
//  clk   : clock, all state updates on the rising edge
//  reset : synchronous, active-low; clears pc, sp and stack_err, overrides any op
//  bus   : program_counter_stack_if.slave
//          in : ce, halt, op (pc_op_e), imm [LO_W], bus_in [WORD_W]
//          out: pc (registered), sp, stack_full, stack_empty, stack_err (sticky)
// Build option: define PC_BRANCH_REL_EN to make op 6 a relative branch
// (pc + sign_extend(imm)); otherwise op 6 behaves as INC.
module program_counter_stack
  import program_counter_stack_pkg::*;
#(
  parameter int unsigned PC_W        = PcWDefault,
  parameter int unsigned LO_W        = LoWDefault,
  parameter int unsigned WORD_W      = WordWDefault,
  parameter int unsigned STACK_DEPTH = StackDepthDefault
) (
  input logic                   clk,
  input logic                   reset,
  program_counter_stack_if.slave bus
);

  localparam int unsigned HI_W = PC_W - LO_W;
  localparam int unsigned SP_W = $clog2(STACK_DEPTH + 1);
  localparam logic [PC_W-1:0] PcOne = PC_W'(1);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] jmp_tgt;
  logic [PC_W-1:0] stk_dout;
  logic [SP_W-1:0] stk_sp;
  logic            stk_full, stk_empty;
  logic            err_q, err_d;
  logic            upd;
  logic            push, pop;

  assign upd     = bus.ce & ~bus.halt;
  assign pc_inc  = pc_q + PcOne;
  assign jmp_tgt = {bus.bus_in[HI_W-1:0], bus.imm};

  // The stack module ignores a push when full and a pop when empty.
  assign push = upd & (bus.op == PC_CALL);
  assign pop  = upd & (bus.op == PC_RET);

  pc_return_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (PC_W)
  ) u_stack (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (pc_inc),
    .dout_o  (stk_dout),
    .sp_o    (stk_sp),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  always_comb begin
    pc_d  = pc_q;
    err_d = err_q;
    if (upd) begin
      unique case (bus.op)
        PC_NOP:  pc_d = pc_q;
        PC_INC:  pc_d = pc_inc;
        PC_SJMP: pc_d = {pc_q[PC_W-1:LO_W], bus.imm};
        PC_JMP:  pc_d = jmp_tgt;
        PC_CALL: begin
          if (stk_full) begin
            pc_d  = pc_inc;
            err_d = 1'b1;
          end else begin
            pc_d = jmp_tgt;
          end
        end
        PC_RET: begin
          if (stk_empty) begin
            pc_d  = pc_inc;
            err_d = 1'b1;
          end else begin
            pc_d = stk_dout;
          end
        end
`ifdef PC_BRANCH_REL_EN
        PC_BRREL: pc_d = pc_q + {{HI_W{bus.imm[LO_W-1]}}, bus.imm};
`else
        PC_BRREL: pc_d = pc_inc;
`endif
        PC_RSVD: pc_d = pc_inc;
        default: pc_d = pc_inc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.sp          = stk_sp;
  assign bus.stack_full  = stk_full;
  assign bus.stack_empty = stk_empty;
  assign bus.stack_err   = err_q;

endmodule

// File: tb/tb_program_counter_stack.sv
// Directed bench for program_counter_stack at default widths (8/4/4, depth 4).
// A queue-based model tracks pc, return addresses and the error flag; a negedge
// process compares every output against it each cycle, and literal checks pin
// key values. Honours PC_BRANCH_REL_EN for op 6.
module tb_program_counter_stack;
  import program_counter_stack_pkg::*;

  logic clk;
  logic reset;

  program_counter_stack_if bus_if ();

  program_counter_stack dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  bit chk_en   = 1'b0;

  // Model state
  logic [7:0] m_pc;
  logic [7:0] m_stk[$];
  bit         m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit c, input bit h, input logic [2:0] op,
                            input logic [3:0] imm, input logic [3:0] hi);
    int off;
    if (!r) begin
      m_pc = 8'h00;
      m_stk.delete();
      m_err = 1'b0;
    end else if (c && !h) begin
      case (op)
        3'd0: ;
        3'd2: m_pc = {m_pc[7:4], imm};
        3'd3: m_pc = {hi, imm};
        3'd4: begin
          if (m_stk.size() == 4) begin
            m_err = 1'b1;
            m_pc  = m_pc + 8'd1;
          end else begin
            m_stk.push_back(m_pc + 8'd1);
            m_pc = {hi, imm};
          end
        end
        3'd5: begin
          if (m_stk.size() == 0) begin
            m_err = 1'b1;
            m_pc  = m_pc + 8'd1;
          end else begin
            m_pc = m_stk.pop_back();
          end
        end
`ifdef PC_BRANCH_REL_EN
        3'd6: begin
          off  = (imm >= 4'd8) ? int'(imm) - 16 : int'(imm);
          m_pc = 8'(int'(m_pc) + off);
        end
`endif
        default: m_pc = m_pc + 8'd1;
      endcase
    end
  endtask

  // One clock of stimulus: drive after the falling edge, return just after the rising edge.
  task automatic cyc(input bit r, input bit c, input bit h, input logic [2:0] op,
                     input logic [3:0] imm, input logic [3:0] hi);
    @(negedge clk);
    #1;
    reset         = r;
    bus_if.ce     = c;
    bus_if.halt   = h;
    bus_if.op     = pc_op_e'(op);
    bus_if.imm    = imm;
    bus_if.bus_in = hi;
    model_step(r, c, h, op, imm, hi);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [2:0] op, input logic [3:0] imm, input logic [3:0] hi);
    cyc(1'b1, 1'b1, 1'b0, op, imm, hi);
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", 32'(bus_if.pc), 32'(m_pc));
      chk("sp", 32'(bus_if.sp), 32'(m_stk.size()));
      chk("stack_full", 32'(bus_if.stack_full), 32'(m_stk.size() == 4));
      chk("stack_empty", 32'(bus_if.stack_empty), 32'(m_stk.size() == 0));
      chk("stack_err", 32'(bus_if.stack_err), 32'(m_err));
    end
  end

  initial begin
    reset         = 1'b0;
    bus_if.ce     = 1'b0;
    bus_if.halt   = 1'b0;
    bus_if.op     = PC_NOP;
    bus_if.imm    = '0;
    bus_if.bus_in = '0;

    // 1. reset, INC sequence, wrap
    cyc(1'b0, 1'b1, 1'b0, 3'd1, 4'h0, 4'h0);
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 4'h0);
    chk_en = 1'b1;
    chk("reset_pc", 32'(bus_if.pc), 32'h00);
    chk("reset_sp", 32'(bus_if.sp), 32'd0);
    chk("reset_err", 32'(bus_if.stack_err), 32'd0);
    chk("reset_empty", 32'(bus_if.stack_empty), 32'd1);
    run(3'd1, 4'h0, 4'h0); chk("inc1", 32'(bus_if.pc), 32'h01);
    run(3'd1, 4'h0, 4'h0); chk("inc2", 32'(bus_if.pc), 32'h02);
    run(3'd1, 4'h0, 4'h0); chk("inc3", 32'(bus_if.pc), 32'h03);
    run(3'd3, 4'hF, 4'hF); chk("jmp_ff", 32'(bus_if.pc), 32'hFF);
    run(3'd1, 4'h0, 4'h0); chk("inc_wrap", 32'(bus_if.pc), 32'h00);

    // 2. SJMP, JMP, halt and ce gating
    run(3'd3, 4'h5, 4'h3); chk("jmp_35", 32'(bus_if.pc), 32'h35);
    run(3'd2, 4'hA, 4'h7); chk("sjmp", 32'(bus_if.pc), 32'h3A);
    cyc(1'b1, 1'b1, 1'b1, 3'd3, 4'h2, 4'hC); chk("halt_hold", 32'(bus_if.pc), 32'h3A);
    cyc(1'b1, 1'b0, 1'b0, 3'd3, 4'h2, 4'hC); chk("ce_hold", 32'(bus_if.pc), 32'h3A);
    run(3'd3, 4'h2, 4'hC); chk("jmp_c2", 32'(bus_if.pc), 32'hC2);

    // 3. CALL / RET pair
    run(3'd3, 4'h0, 4'h1);
    run(3'd4, 4'h0, 4'h8);
    chk("call_pc", 32'(bus_if.pc), 32'h80);
    chk("call_sp", 32'(bus_if.sp), 32'd1);
    run(3'd5, 4'h0, 4'h0);
    chk("ret_pc", 32'(bus_if.pc), 32'h11);
    chk("ret_sp", 32'(bus_if.sp), 32'd0);
    chk("ret_err", 32'(bus_if.stack_err), 32'd0);

    // 4. overflow and underflow
    run(3'd3, 4'h0, 4'h2);
    run(3'd4, 4'h1, 4'h3);
    run(3'd4, 4'h2, 4'h4);
    run(3'd4, 4'h3, 4'h5);
    run(3'd4, 4'h4, 4'h6);
    chk("full_flag", 32'(bus_if.stack_full), 32'd1);
    run(3'd4, 4'h5, 4'h7);
    chk("ovf_pc", 32'(bus_if.pc), 32'h65);
    chk("ovf_sp", 32'(bus_if.sp), 32'd4);
    chk("ovf_err", 32'(bus_if.stack_err), 32'd1);
    run(3'd5, 4'h0, 4'h0); chk("ret4", 32'(bus_if.pc), 32'h54);
    run(3'd5, 4'h0, 4'h0); chk("ret3", 32'(bus_if.pc), 32'h43);
    run(3'd5, 4'h0, 4'h0); chk("ret2", 32'(bus_if.pc), 32'h32);
    run(3'd5, 4'h0, 4'h0); chk("ret1", 32'(bus_if.pc), 32'h21);
    run(3'd5, 4'h0, 4'h0);
    chk("unf_pc", 32'(bus_if.pc), 32'h22);
    chk("unf_sp", 32'(bus_if.sp), 32'd0);
    chk("unf_err", 32'(bus_if.stack_err), 32'd1);

    // 5. reset beats a CALL with sp=2
    run(3'd4, 4'h0, 4'h9);
    run(3'd4, 4'h0, 4'hA);
    chk("pre_rst_sp", 32'(bus_if.sp), 32'd2);
    cyc(1'b0, 1'b1, 1'b0, 3'd4, 4'h0, 4'hB);
    chk("rst_call_pc", 32'(bus_if.pc), 32'h00);
    chk("rst_call_sp", 32'(bus_if.sp), 32'd0);
    chk("rst_call_err", 32'(bus_if.stack_err), 32'd0);

    // 6. op 6 / op 7 / NOP
    run(3'd3, 4'h5, 4'h0);
    run(3'd6, 4'hE, 4'h0);
`ifdef PC_BRANCH_REL_EN
    chk("brrel_back", 32'(bus_if.pc), 32'h03);
`else
    chk("op6_inc", 32'(bus_if.pc), 32'h06);
`endif
    run(3'd3, 4'hF, 4'hF);
    run(3'd6, 4'h3, 4'h0);
`ifdef PC_BRANCH_REL_EN
    chk("brrel_wrap", 32'(bus_if.pc), 32'h02);
`else
    chk("op6_wrap", 32'(bus_if.pc), 32'h00);
`endif
    run(3'd3, 4'h7, 4'h4);
    run(3'd7, 4'h0, 4'h0); chk("rsvd_inc", 32'(bus_if.pc), 32'h48);
    run(3'd0, 4'h9, 4'h9); chk("nop_hold", 32'(bus_if.pc), 32'h48);

    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
